// File: rtl/memory_request_unit.sv
// memory_request_unit: issues fetch/data requests, holds data requests until dhit, sticky halt and stats.
module memory_request_unit #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic             datomic,
  input  logic             halt,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             dmematomic,
  output logic             pc_en,
  output logic             halted,
  output logic             timeout_err,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DWAIT, HALTED} state_t;

  state_t           state_q, state_d;
  logic             dren_q, dren_d, dwen_q, dwen_d, datomic_q, datomic_d;
  logic             terr_q, terr_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0] ret_q, ret_d, stl_q, stl_d;
  logic             issue, done, stall;

  always_ff @(posedge CLK or posedge RST)
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;

  always_comb begin
    state_d = (state_q == IDLE && ihit) ? (halt ? HALTED : (dREN | dWEN) ? DWAIT : IDLE) :
              (state_q == DWAIT && dhit) ? IDLE : state_q;
  end

  always_comb begin
    imemREN = state_q == IDLE;
    halted  = state_q == HALTED;
    issue   = state_q == IDLE && ihit && !halt && (dREN || dWEN);
    done    = state_q == DWAIT && dhit;
    stall   = state_q == DWAIT && !dhit;
    pc_en   = (state_q == IDLE && ihit && !halt && !dREN && !dWEN) || done;
  end

  // Request bits latch on issue and hold until the completing dhit.
  always_comb begin
    dren_d    = issue ? dREN    : done ? 1'b0 : dren_q;
    dwen_d    = issue ? dWEN    : done ? 1'b0 : dwen_q;
    datomic_d = issue ? datomic : done ? 1'b0 : datomic_q;
    tmo_d     = issue ? '0 : (stall && tmo_q != TMO_LAST) ? tmo_q + 1'b1 : tmo_q;
    terr_d    = terr_q || (stall && tmo_q == TMO_LAST);
    ret_d     = (pc_en && !(&ret_q)) ? ret_q + 1'b1 : ret_q;
    stl_d     = (stall && !(&stl_q)) ? stl_q + 1'b1 : stl_q;
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      dren_q    <= 1'b0;
      dwen_q    <= 1'b0;
      datomic_q <= 1'b0;
      terr_q    <= 1'b0;
      tmo_q     <= '0;
      ret_q     <= '0;
      stl_q     <= '0;
    end else begin
      dren_q    <= dren_d;
      dwen_q    <= dwen_d;
      datomic_q <= datomic_d;
      terr_q    <= terr_d;
      tmo_q     <= tmo_d;
      ret_q     <= ret_d;
      stl_q     <= stl_d;
    end

  assign dmemREN     = dren_q;
  assign dmemWEN     = dwen_q;
  assign dmematomic  = datomic_q;
  assign timeout_err = terr_q;
  assign retire_cnt  = ret_q;
  assign stall_cnt   = stl_q;
endmodule

// File: tb/tb_memory_request_unit.sv
// tb_memory_request_unit: directed stimulus, per-cycle model comparison plus literal pins.
module tb_memory_request_unit;
  localparam int CW  = 3;
  localparam int TO  = 8;
  localparam int MAX = (1 << CW) - 1;

  logic CLK = 1'b0, RST = 1'b1;
  logic dREN = 1'b0, dWEN = 1'b0, datomic = 1'b0, halt = 1'b0, ihit = 1'b0, dhit = 1'b0;
  logic imemREN, dmemREN, dmemWEN, dmematomic, pc_en, halted, timeout_err;
  logic [CW-1:0] retire_cnt, stall_cnt;

  int checks = 0, errors = 0;
  int m_mode = 0, m_ret = 0, m_stl = 0, m_wt = 0;
  bit m_r = 0, m_w = 0, m_a = 0, m_te = 0;

  memory_request_unit #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .halt(halt),
    .ihit(ihit), .dhit(dhit), .imemREN(imemREN), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmematomic(dmematomic), .pc_en(pc_en), .halted(halted), .timeout_err(timeout_err),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 fetching, 1 waiting on data, 2 halted; counts kept unbounded and clipped on compare.
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_mode = 0; m_ret = 0; m_stl = 0; m_wt = 0;
      m_r = 0; m_w = 0; m_a = 0; m_te = 0;
    end else if (m_mode == 0 && ihit) begin
      if (halt) m_mode = 2;
      else if (dREN || dWEN) begin
        m_r = dREN; m_w = dWEN; m_a = datomic; m_wt = 0; m_mode = 1;
      end else m_ret++;
    end else if (m_mode == 1) begin
      if (dhit) begin
        m_ret++; m_r = 0; m_w = 0; m_a = 0; m_mode = 0;
      end else begin
        m_stl++; m_wt++;
        if (m_wt >= TO) m_te = 1;
      end
    end
  end

  always @(negedge CLK) begin
    chk("imemREN", 32'(imemREN), 32'(m_mode == 0));
    chk("dmemREN", 32'(dmemREN), 32'(m_r));
    chk("dmemWEN", 32'(dmemWEN), 32'(m_w));
    chk("dmematomic", 32'(dmematomic), 32'(m_a));
    chk("pc_en", 32'(pc_en),
        32'((m_mode == 0 && ihit && !halt && !dREN && !dWEN) || (m_mode == 1 && dhit)));
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("timeout_err", 32'(timeout_err), 32'(m_te));
    chk("retire_cnt", 32'(retire_cnt), 32'(m_ret > MAX ? MAX : m_ret));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stl > MAX ? MAX : m_stl));
  end

  task automatic step(input logic i, input logic d, input logic r, input logic w,
                      input logic a, input logic h);
    ihit = i; dhit = d; dREN = r; dWEN = w; datomic = a; halt = h;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset;
    {ihit, dhit, dREN, dWEN, datomic, halt} = '0;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("reset_retire", 32'(retire_cnt), 0);
    chk("reset_imemREN", 32'(imemREN), 1);

    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("alu_retire", 32'(retire_cnt), 3);
    chk("alu_stall", 32'(stall_cnt), 0);
    chk("alu_dmemREN", 32'(dmemREN), 0);

    do_reset();
    step(1, 0, 1, 0, 0, 0);
    chk("ld_dmemREN", 32'(dmemREN), 1);
    chk("ld_imemREN", 32'(imemREN), 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);
    dhit = 1'b1;
    #1;
    chk("ld_pc_en_on_dhit", 32'(pc_en), 1);
    @(posedge CLK);
    #1;
    dhit = 1'b0;
    chk("ld_dmemREN_after", 32'(dmemREN), 0);
    chk("ld_stall", 32'(stall_cnt), 4);
    chk("ld_retire", 32'(retire_cnt), 1);

    do_reset();
    step(1, 0, 0, 1, 1, 0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(1, 0, 1, 1, 0, 1);
    chk("sc_wen_held", 32'(dmemWEN), 1);
    chk("sc_atomic_held", 32'(dmematomic), 1);
    chk("sc_ren_clear", 32'(dmemREN), 0);
    step(1, 1, 0, 0, 0, 0);
    chk("sc_wen_done", 32'(dmemWEN), 0);
    chk("sc_atomic_done", 32'(dmematomic), 0);
    chk("sc_retire", 32'(retire_cnt), 1);

    do_reset();
    step(1, 0, 1, 0, 0, 1);
    chk("halt_halted", 32'(halted), 1);
    chk("halt_no_req", 32'(dmemREN), 0);
    for (int i = 0; i < 12; i++) step(i[0], !i[0], i[1], 0, 0, 0);
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_imemREN", 32'(imemREN), 0);

    do_reset();
    step(1, 0, 1, 0, 0, 0);
    repeat (7) step(0, 0, 0, 0, 0, 0);
    chk("to_not_yet", 32'(timeout_err), 0);
    step(0, 0, 0, 0, 0, 0);
    chk("to_flag", 32'(timeout_err), 1);
    chk("to_req_held", 32'(dmemREN), 1);
    step(0, 1, 0, 0, 0, 0);
    chk("to_done_req", 32'(dmemREN), 0);
    chk("to_sticky", 32'(timeout_err), 1);
    step(1, 0, 0, 0, 0, 0);

    do_reset();
    step(1, 0, 1, 0, 0, 0);
    repeat (9) step(0, 0, 0, 0, 0, 0);
    chk("ar_pre_terr", 32'(timeout_err), 1);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("ar_dmemREN", 32'(dmemREN), 0);
    chk("ar_terr", 32'(timeout_err), 0);
    chk("ar_stall", 32'(stall_cnt), 0);
    chk("ar_retire", 32'(retire_cnt), 0);
    chk("ar_imemREN", 32'(imemREN), 1);
    @(posedge CLK);
    #1;
    RST = 1'b0;

    repeat (9) step(1, 0, 0, 0, 0, 0);
    chk("sat_retire", 32'(retire_cnt), 7);
    step(0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_request_unit.md
Name: memory_request_unit

Overview:
- Sits directly downstream of the control unit in each core's datapath.
- Consumes the decoded dREN, dWEN, datomic and halt signals, plus the cache hit signals.
- Drives the instruction and data memory request lines toward the caches, and the PC enable into the datapath.
- Holds each data request stable until the cache reports a hit, makes halt sticky, and keeps retire, stall and timeout statistics.

Parameters:
- CNT_W, 32: width of the retire and stall counters; both saturate at all-ones.
- TIMEOUT, 1024: consecutive DWAIT cycles without dhit before a timeout error is flagged.

Ports:
- CLK  input  1  core clock; all state updates on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- dREN  input  1  from control unit: current instruction is a load.
- dWEN  input  1  from control unit: current instruction is a store.
- datomic  input  1  from control unit: current load/store is LL/SC.
- halt  input  1  from control unit: current instruction is HALT.
- ihit  input  1  icache hit for the current fetch.
- dhit  input  1  dcache hit for the outstanding data request.
- imemREN  output  1  instruction fetch request.
- dmemREN  output  1  data read request (registered).
- dmemWEN  output  1  data write request (registered).
- dmematomic  output  1  outstanding request is atomic (registered).
- pc_en  output  1  PC and register-file commit enable (combinational).
- halted  output  1  sticky halt indication (registered).
- timeout_err  output  1  sticky data-request timeout flag.
- retire_cnt  output  CNT_W  instructions retired.
- stall_cnt  output  CNT_W  cycles spent waiting on dhit.

Behaviour:
- States: IDLE, DWAIT, HALTED. Reset: IDLE, all registered outputs 0, counters 0, internal timeout counter 0. Reset is asynchronous, including mid-request; no partial request survives.
- IDLE:
  - imemREN=1; dmemREN=dmemWEN=dmematomic=0.
  - ihit=0: pc_en=0, stay.
  - ihit=1 & halt=1: pc_en=0, go HALTED. halt has priority over dREN/dWEN.
  - ihit=1 & (dREN|dWEN) & ~halt: pc_en=0. Next edge: dmemREN<=dREN, dmemWEN<=dWEN, dmematomic<=datomic, timeout counter<=0, go DWAIT.
  - ihit=1 & ~dREN & ~dWEN & ~halt: pc_en=1, retire_cnt+1, stay.
- DWAIT:
  - imemREN=0; ihit is ignored. Data outputs are held stable regardless of input changes.
  - dhit=1: pc_en=1 in the same cycle, retire_cnt+1. Next edge: clear dmemREN/dmemWEN/dmematomic, go IDLE. Minimum load/store latency is 2 cycles (ihit cycle + dhit cycle).
  - dhit=0: pc_en=0, stall_cnt+1, timeout counter+1.
  - When the timeout counter reaches TIMEOUT-1 with dhit=0: timeout_err<=1 (sticky until reset). The request continues to be held and no state change occurs.
- HALTED: imemREN=dmemREN=dmemWEN=dmematomic=pc_en=0; halted=1; absorbing until RST.
- Counters saturate at 2^CNT_W-1 and never wrap.
- dREN and dWEN both asserted is illegal from the control unit. If it occurs, both outputs are registered as given; no checking is done.
- Simultaneous ihit and dhit in IDLE: dhit is ignored. Simultaneous ihit and dhit in DWAIT: only dhit is acted on.

Test Plan:
- Reset then 3 ALU instructions with ihit=1 each cycle → imemREN=1, pc_en=1 for 3 cycles, retire_cnt=3, stall_cnt=0, dmemREN=0.
- Load: ihit=1, dREN=1 → pc_en=0. Next cycle dmemREN=1, imemREN=0. Hold dhit=0 for 4 cycles, then dhit=1 → pc_en=1 on the dhit cycle, dmemREN=0 after, stall_cnt=4, retire_cnt=1.
- SC: dWEN=1, datomic=1 → dmemWEN=1 and dmematomic=1 held stable while dREN/dWEN/datomic inputs toggle and dhit=0. Both clear after dhit.
- halt=1 with ihit=1 and dREN=1 → HALTED: halted=1, no data request issued, all requests 0 for 10+ cycles despite ihit/dhit pulses.
- TIMEOUT=8: data request with dhit held 0 → timeout_err=1 after 8 cycles, dmemREN still 1. dhit then completes normally; timeout_err stays 1.
- RST asserted asynchronously mid-DWAIT (between clock edges) → dmemREN=0 immediately; state IDLE, counters 0, timeout_err=0.
- CNT_W=3: 9 ALU retirements → retire_cnt saturates at 7.
